// File: rtl/fifo_defs.sv
// rtl/fifo_defs.sv - shared widths and depth for the push-out FIFO and its downstream packet counter
package fifo_defs;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = PTR_W + 1;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, one synchronous write port, one combinational read port
module fifo_mem
  import fifo_defs::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_push_out.sv
// rtl/fifo_push_out.sv - FIFO stage whose registered valid_out strobe pushes the downstream packet counter
// Optional sticky overflow/underflow flag enabled by defining FIFO_ERROR_EN.
module fifo_push_out
  import fifo_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              error
);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_rdata;
  logic              w_pop_ok;
  logic              w_push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push; empty never bypasses.
  assign w_pop_ok  = pop & ~r_empty;
  assign w_push_ok = push & (~r_full | w_pop_ok);

  fifo_mem u_mem (
    .clk   (clk),
    .we    (w_push_ok),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rdata;
      end
      r_valid_out <= w_pop_ok;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == CNT_W'(DEPTH));
      r_empty     <= (w_count_next == '0);
    end
  end

`ifdef FIFO_ERROR_EN
  logic r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((push & r_full & ~pop) | (pop & r_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;

endmodule
